wb_commit_unit: RTL and testbench

- Writeback-side consumer of the exec→writeback and dmem→writeback pipeline outputs.
- Owns the architectural general register file (x0–x31) and the PC register.
- Drives both back to the exec and dmem stages as the current-state view.
- One regfile write port per cycle; simultaneous exec and load results are serialized through a small pending-write queue, with a stall to upstream.

---
 rtl/wb_commit_unit.sv | 157 +++++++++++++++
 tb/tb_wb_commit_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: writeback commit stage owning the architectural regfile and PC.
// One regfile write per cycle; surplus results wait in a small circular pending queue.
`default_nettype none

module wb_commit_unit #(
    parameter int                 BIN_DIG    = 32,
    parameter logic [BIN_DIG-1:0] RESET_PC   = '0,
    parameter int                 PEND_DEPTH = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        ex_valid,
    input  logic [4:0]                  ex_rd,
    input  logic [BIN_DIG-1:0]          ex_rd_value,
    input  logic [BIN_DIG-1:0]          ex_next_pc,
    input  logic                        ld_active,
    input  logic [4:0]                  ld_rd,
    input  logic [BIN_DIG-1:0]          ld_rd_value,
    output logic                        wb_stall,
    output logic                        wb_busy,
    output logic [BIN_DIG-1:0]          curr_pc_reg,
    output logic [31:0][BIN_DIG-1:0]    curr_general_reg,
    output logic [31:0]                 commit_count
);

    localparam int PTR_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
    localparam int CNT_W = $clog2(PEND_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PEND_DEPTH - 1);
    localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(PEND_DEPTH - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    logic [4:0]         q_rd  [PEND_DEPTH];
    logic [BIN_DIG-1:0] q_val [PEND_DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;

    logic               accept;
    logic               ld_new;
    logic               ex_new;
    logic               deq;

    logic               wr_en;
    logic [4:0]         wr_rd;
    logic [BIN_DIG-1:0] wr_val;

    logic               enq_a_en;
    logic [4:0]         enq_a_rd;
    logic [BIN_DIG-1:0] enq_a_val;
    logic               enq_b_en;
    logic [1:0]         enq_cnt;

    assign wb_stall = (count >= STALL_AT);
    assign wb_busy  = (count != '0);
    assign accept   = !wb_stall;
    assign deq      = (count != '0);

    // x0 writes are discarded here so they never occupy the queue or the counter.
    assign ld_new = accept && ld_active && (ld_rd != 5'd0);
    assign ex_new = accept && ex_valid  && (ex_rd != 5'd0);

    // Program order is queue head, then load, then exec; the oldest takes the write port.
    always_comb begin
        wr_en     = 1'b0;
        wr_rd     = 5'd0;
        wr_val    = '0;
        enq_a_en  = 1'b0;
        enq_a_rd  = 5'd0;
        enq_a_val = '0;
        enq_b_en  = 1'b0;
        if (deq) begin
            wr_en  = 1'b1;
            wr_rd  = q_rd[head];
            wr_val = q_val[head];
            if (ld_new) begin
                enq_a_en  = 1'b1;
                enq_a_rd  = ld_rd;
                enq_a_val = ld_rd_value;
                enq_b_en  = ex_new;
            end else if (ex_new) begin
                enq_a_en  = 1'b1;
                enq_a_rd  = ex_rd;
                enq_a_val = ex_rd_value;
            end
        end else if (ld_new) begin
            wr_en  = 1'b1;
            wr_rd  = ld_rd;
            wr_val = ld_rd_value;
            if (ex_new) begin
                enq_a_en  = 1'b1;
                enq_a_rd  = ex_rd;
                enq_a_val = ex_rd_value;
            end
        end else if (ex_new) begin
            wr_en  = 1'b1;
            wr_rd  = ex_rd;
            wr_val = ex_rd_value;
        end
    end

    assign enq_cnt    = {1'b0, enq_a_en} + {1'b0, enq_b_en};
    assign count_next = count - CNT_W'(deq) + CNT_W'(enq_cnt);

    // Second enqueue (only with a draining head) is always the exec result.
    always_ff @(posedge CLK) begin
        if (enq_a_en) begin
            q_rd[tail]  <= enq_a_rd;
            q_val[tail] <= enq_a_val;
        end
        if (enq_b_en) begin
            q_rd[ptr_inc(tail)]  <= ex_rd;
            q_val[ptr_inc(tail)] <= ex_rd_value;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            count <= count_next;
            if (deq) begin
                head <= ptr_inc(head);
            end
            if (enq_b_en) begin
                tail <= ptr_inc(ptr_inc(tail));
            end else if (enq_a_en) begin
                tail <= ptr_inc(tail);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            curr_general_reg <= '0;
            curr_pc_reg      <= RESET_PC;
            commit_count     <= 32'd0;
        end else begin
            if (wr_en && (wr_rd != 5'd0)) begin
                curr_general_reg[wr_rd] <= wr_val;
                commit_count            <= commit_count + 32'd1;
            end
            // PC follows every accepted exec result, even one whose write is queued or dropped.
            if (accept && ex_valid) begin
                curr_pc_reg <= ex_next_pc;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: vector table plus an in-order commit scoreboard.
`default_nettype none

module tb_wb_commit_unit;

    localparam int BW = 32;

    logic                   CLK = 1'b0;
    logic                   RST = 1'b1;
    logic                   ex_valid = 1'b0;
    logic [4:0]             ex_rd = '0;
    logic [BW-1:0]          ex_rd_value = '0;
    logic [BW-1:0]          ex_next_pc = '0;
    logic                   ld_active = 1'b0;
    logic [4:0]             ld_rd = '0;
    logic [BW-1:0]          ld_rd_value = '0;
    logic                   wb_stall;
    logic                   wb_busy;
    logic [BW-1:0]          curr_pc_reg;
    logic [31:0][BW-1:0]    curr_general_reg;
    logic [31:0]            commit_count;

    wb_commit_unit #(.BIN_DIG(BW), .RESET_PC('0), .PEND_DEPTH(2)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .ex_valid         (ex_valid),
        .ex_rd            (ex_rd),
        .ex_rd_value      (ex_rd_value),
        .ex_next_pc       (ex_next_pc),
        .ld_active        (ld_active),
        .ld_rd            (ld_rd),
        .ld_rd_value      (ld_rd_value),
        .wb_stall         (wb_stall),
        .wb_busy          (wb_busy),
        .curr_pc_reg      (curr_pc_reg),
        .curr_general_reg (curr_general_reg),
        .commit_count     (commit_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          ld;
        logic [4:0]    ld_rd;
        logic [BW-1:0] ld_val;
        logic          ex;
        logic [4:0]    ex_rd;
        logic [BW-1:0] ex_val;
        logic [BW-1:0] ex_pc;
        logic          exp_stall;
        logic          exp_busy;
        logic [BW-1:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [4:0]    rd;
        logic [BW-1:0] val;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    int          total = 0;
    int          bad = 0;
    int          pushes = 0;
    logic [31:0] last_cc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_nostall();
        int n = 0;
        while (wb_stall && n < 20) begin
            tick();
            n++;
        end
        if (wb_stall) chk("stall_timeout", {31'd0, wb_stall}, 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (wb_busy && n < 20) begin
            tick();
            n++;
        end
        if (wb_busy) chk("busy_timeout", {31'd0, wb_busy}, 32'd0);
        tick();
    endtask

    task automatic clear_inputs();
        ld_active = 1'b0; ld_rd = '0; ld_rd_value = '0;
        ex_valid = 1'b0; ex_rd = '0; ex_rd_value = '0; ex_next_pc = '0;
    endtask

    // Expected commits are queued in program order at drive time: load before exec.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        wait_nostall();
        ld_active = v.ld; ld_rd = v.ld_rd; ld_rd_value = v.ld_val;
        ex_valid = v.ex; ex_rd = v.ex_rd; ex_rd_value = v.ex_val; ex_next_pc = v.ex_pc;
        if (v.ld && v.ld_rd != 5'd0) begin
            e.rd = v.ld_rd; e.val = v.ld_val; sb.push_back(e); pushes++;
        end
        if (v.ex && v.ex_rd != 5'd0) begin
            e.rd = v.ex_rd; e.val = v.ex_val; sb.push_back(e); pushes++;
        end
        tick();
        clear_inputs();
        chk({tag, "_stall"}, {31'd0, wb_stall}, {31'd0, v.exp_stall});
        chk({tag, "_busy"},  {31'd0, wb_busy},  {31'd0, v.exp_busy});
        chk({tag, "_pc"},    curr_pc_reg, v.exp_pc);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            last_cc = '0;
        end else if (commit_count != last_cc) begin
            if (commit_count != last_cc + 32'd1) chk("cc_step", commit_count, last_cc + 32'd1);
            if (sb.size() == 0) begin
                chk("sb_unexpected_commit", commit_count, last_cc);
            end else begin
                e = sb.pop_front();
                chk("commit_val", curr_general_reg[e.rd], e.val);
            end
            last_cc = commit_count;
        end
    end

    initial begin
        logic all_zero;
        vec_t v;

        //          ld  ldrd  ldval          ex  exrd  exval          expc           stall busy pc
        vecs[0] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'hDEADBEEF, 32'h4,  1'b0, 1'b0, 32'h4};
        vecs[1] = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       32'h8,  1'b1, 1'b1, 32'h8};
        vecs[2] = '{1'b1, 5'd7,  32'hAA,       1'b1, 5'd7,  32'hBB,       32'hC,  1'b1, 1'b1, 32'hC};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hFFFFFFFF, 32'h10, 1'b0, 1'b0, 32'h10};
        vecs[4] = '{1'b1, 5'd9,  32'h1234,     1'b0, 5'd0,  32'h0,        32'h0,  1'b0, 1'b0, 32'h10};
        vecs[5] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  32'hFFFFFFFF, 32'h14, 1'b0, 1'b0, 32'h14};
        vecs[6] = '{1'b1, 5'd0,  32'h9999,     1'b1, 5'd12, 32'h55,       32'h18, 1'b0, 1'b0, 32'h18};
        vecs[7] = '{1'b1, 5'd31, 32'hCAFE,     1'b1, 5'd1,  32'h77,       32'h1C, 1'b1, 1'b1, 32'h1C};

        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;

        all_zero = 1'b1;
        for (int i = 0; i < 32; i++) if (curr_general_reg[i] !== '0) all_zero = 1'b0;
        chk("rst_regs_zero", {31'd0, all_zero}, 32'd1);
        chk("rst_pc", curr_pc_reg, 32'h0);
        chk("rst_stall", {31'd0, wb_stall}, 32'd0);
        chk("rst_busy", {31'd0, wb_busy}, 32'd0);
        chk("rst_cc", commit_count, 32'd0);

        for (int i = 0; i < 8; i++) apply(vecs[i], $sformatf("vec%0d", i));
        wait_idle();
        chk("x5_final", curr_general_reg[5], 32'hDEADBEEF);
        chk("x7_final", curr_general_reg[7], 32'hBB);
        chk("x0_zero", curr_general_reg[0], 32'h0);
        chk("cc_total", commit_count, pushes);
        chk("sb_drained", sb.size(), 32'd0);

        // Inputs presented while stalled must be ignored entirely.
        v = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 32'h40, 1'b1, 1'b1, 32'h40};
        apply(v, "pre_stall");
        ld_active = 1'b1; ld_rd = 5'd21; ld_rd_value = 32'h888;
        ex_valid = 1'b1; ex_rd = 5'd20; ex_rd_value = 32'h999; ex_next_pc = 32'h100;
        tick();
        clear_inputs();
        chk("stall_pc_hold", curr_pc_reg, 32'h40);
        wait_idle();
        chk("stall_x20", curr_general_reg[20], 32'h0);
        chk("stall_x21", curr_general_reg[21], 32'h0);
        chk("stall_cc", commit_count, pushes);

        // Reset while x11 is still pending: it must never be written.
        v = '{1'b1, 5'd10, 32'h5A, 1'b1, 5'd11, 32'h6B, 32'h200, 1'b1, 1'b1, 32'h200};
        apply(v, "pre_rst");
        RST = 1'b1;
        sb.delete();
        pushes = 0;
        tick();
        RST = 1'b0;
        chk("mrst_x10", curr_general_reg[10], 32'h0);
        chk("mrst_x11", curr_general_reg[11], 32'h0);
        chk("mrst_pc", curr_pc_reg, 32'h0);
        chk("mrst_busy", {31'd0, wb_busy}, 32'd0);
        chk("mrst_stall", {31'd0, wb_stall}, 32'd0);
        chk("mrst_cc", commit_count, 32'd0);
        tick();
        tick();
        chk("mrst_x11_later", curr_general_reg[11], 32'h0);
        chk("mrst_cc_later", commit_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
